// File: rtl/scan_pkg.sv
// Shared definitions for the decoder select sequencer: slot count, select width
// and the scan FSM state encoding.
package scan_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_next_sel.sv
// Rotate-priority encoder: finds the next enabled slot after cur (wrapping back to
// cur itself), or the lowest enabled slot when from_start is set.
module scan_next_sel
    import scan_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic [SEL_W-1:0]     cur,
    input  logic                 from_start,
    output logic [SEL_W-1:0]     nxt,
    output logic                 found,
    output logic                 wrap
);

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] cand;

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        cand  = '0;
        start = from_start ? '0 : cur + SEL_W'(1);
        // The last candidate (offset NUM_SLOTS-1 from start) is cur itself when rotating.
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            cand = start + SEL_W'(k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        wrap = found && !from_start && (nxt <= cur);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Time-multiplexed select sequencer for a 2x4 decoder: each enabled index is held
// for DWELL_CYCLES with sel_valid high, followed by BLANK_CYCLES of dead time.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mask,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_valid,
    output logic       frame_done,
    output logic       idle
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             sel_valid_q, sel_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             idle_q, idle_d;

    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_found;
    logic             nxt_wrap;
    logic             do_select;

    scan_next_sel u_next_sel (
        .mask       (mask),
        .cur        (idx_q),
        .from_start (state_q == ST_IDLE),
        .nxt        (nxt_idx),
        .found      (nxt_found),
        .wrap       (nxt_wrap)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        do_select    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && nxt_found) begin
                    state_d = ST_DWELL;
                    cnt_d   = DWELL_LD;
                    idx_d   = nxt_idx;
                end
            end
            ST_DWELL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        do_select = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    do_select = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // End-of-slot selection shared by the DWELL (no blank) and BLANK exits.
        if (do_select) begin
            if (nxt_found) begin
                state_d      = ST_DWELL;
                cnt_d        = DWELL_LD;
                idx_d        = nxt_idx;
                frame_done_d = nxt_wrap;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end

        sel_valid_d = (state_d == ST_DWELL);
        idle_d      = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sel_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sel_valid_q  <= sel_valid_d;
            frame_done_q <= frame_done_d;
            idle_q       <= idle_d;
        end
    end

    assign sel_a      = idx_q[1];
    assign sel_b      = idx_q[0];
    assign sel_valid  = sel_valid_q;
    assign frame_done = frame_done_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: two instances (one blank cycle, no blank) sharing
// inputs, checked against a slot-timeline model plus directed vectors.
module tb_decoder_scan_ctrl;

    localparam int DW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] mask = 4'hF;

    logic a0, b0, v0, f0, i0;
    logic a1, b1, v1, f1, i1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.CNT_W(16), .DWELL_CYCLES(DW), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .en(en), .mask(mask),
        .sel_a(a0), .sel_b(b0), .sel_valid(v0), .frame_done(f0), .idle(i0)
    );

    decoder_scan_ctrl #(.CNT_W(16), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .mask(mask),
        .sel_a(a1), .sel_b(b1), .sel_valid(v1), .frame_done(f1), .idle(i1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic [1:0] sel;
        logic       valid;
        logic       fd;
        logic       idle;
    } vec_t;

    vec_t tbl[$];

    // Model: per instance, whether a scan is active, the current index and the
    // position inside the current slot (dwell positions first, then blank).
    int m_act [2];
    int m_idx [2];
    int m_pos [2];
    int m_fd  [2];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int len;
            int newi;
            int fnd;
            len = DW + ((m == 0) ? 1 : 0);
            if (rst) begin
                m_act[m] = 0; m_idx[m] = 0; m_pos[m] = 0; m_fd[m] = 0;
            end else if (m_act[m] == 0) begin
                m_fd[m] = 0;
                if (en && mask != 4'h0) begin
                    for (int k = 3; k >= 0; k--) if (mask[k]) m_idx[m] = k;
                    m_act[m] = 1;
                    m_pos[m] = 0;
                end
            end else if (!en) begin
                m_act[m] = 0; m_fd[m] = 0;
            end else if (m_pos[m] == len - 1) begin
                fnd = 0;
                newi = 0;
                for (int k = 1; k <= 4; k++)
                    if (fnd == 0 && mask[(m_idx[m] + k) % 4]) begin
                        newi = (m_idx[m] + k) % 4;
                        fnd = 1;
                    end
                if (fnd != 0) begin
                    m_fd[m]  = (newi <= m_idx[m]) ? 1 : 0;
                    m_idx[m] = newi;
                    m_pos[m] = 0;
                end else begin
                    m_act[m] = 0; m_fd[m] = 0;
                end
            end else begin
                m_pos[m]++;
                m_fd[m] = 0;
            end
        end
    endtask

    task automatic check_models();
        chk("m_sel",    {2'b0, a0, b0}, 4'(m_idx[0]));
        chk("m_valid",  {3'b0, v0}, {3'b0, (m_act[0] != 0) && (m_pos[0] < DW)});
        chk("m_fd",     {3'b0, f0}, 4'(m_fd[0]));
        chk("m_idle",   {3'b0, i0}, {3'b0, m_act[0] == 0});
        chk("nb_sel",   {2'b0, a1, b1}, 4'(m_idx[1]));
        chk("nb_valid", {3'b0, v1}, {3'b0, (m_act[1] != 0) && (m_pos[1] < DW)});
        chk("nb_fd",    {3'b0, f1}, 4'(m_fd[1]));
        chk("nb_idle",  {3'b0, i1}, {3'b0, m_act[1] == 0});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_models();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        vec_t r;

        // Reset with en=1, then a full mask=1111 frame: 3 valid + 1 blank per slot.
        for (int i = 0; i < 2; i++) begin
            r = '{rst: 1'b1, en: 1'b1, mask: 4'hF, sel: 2'd0, valid: 1'b0, fd: 1'b0, idle: 1'b1};
            tbl.push_back(r);
        end
        for (int s = 0; s < 5; s++)
            for (int p = 0; p < 4; p++) begin
                r.rst = 1'b0; r.en = 1'b1; r.mask = 4'hF;
                r.sel = 2'(s % 4);
                r.valid = (p < DW);
                r.fd = (s == 4 && p == 0);
                r.idle = 1'b0;
                tbl.push_back(r);
            end

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; mask = tbl[i].mask;
            cycle();
            chk($sformatf("vec%0d_sel", i),   {2'b0, a0, b0}, {2'b0, tbl[i].sel});
            chk($sformatf("vec%0d_valid", i), {3'b0, v0}, {3'b0, tbl[i].valid});
            chk($sformatf("vec%0d_fd", i),    {3'b0, f0}, {3'b0, tbl[i].fd});
            chk($sformatf("vec%0d_idle", i),  {3'b0, i0}, {3'b0, tbl[i].idle});
        end

        // mask=1010: only odd indices ever valid.
        do_reset();
        en = 1'b1; mask = 4'hA;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("odd_only", {3'b0, v0 && !b0}, 4'h0);
        end

        // Single slot mask=0100: pulse every slot; no-blank instance stays valid.
        do_reset();
        en = 1'b1; mask = 4'h4;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            cnt0 += int'(f0);
            cnt1 += int'(f1);
            chk("nb_valid_cont", {3'b0, v1}, 4'h1);
        end
        chk("single_fd_cnt", 4'(cnt0), 4'd3);
        chk("single_fd_cnt_nb", 4'(cnt1), 4'd5);

        // en dropped on the 2nd dwell cycle of idx 2, then restart from idx 0.
        do_reset();
        en = 1'b1; mask = 4'hF;
        for (int i = 0; i < 10; i++) cycle();
        chk("abort_pre_sel", {2'b0, a0, b0}, 4'd2);
        en = 1'b0;
        cycle();
        chk("abort_sel", {2'b0, a0, b0}, 4'd2);
        chk("abort_valid", {3'b0, v0}, 4'h0);
        chk("abort_idle", {3'b0, i0}, 4'h1);
        chk("abort_fd", {3'b0, f0}, 4'h0);
        en = 1'b1;
        cycle();
        chk("restart_sel", {2'b0, a0, b0}, 4'd0);
        chk("restart_valid", {3'b0, v0}, 4'h1);

        // Mask cleared mid-dwell of idx 1: dwell completes, blank, then idle.
        do_reset();
        en = 1'b1; mask = 4'hF;
        for (int i = 0; i < 5; i++) cycle();
        mask = 4'h0;
        cycle();
        cycle();
        chk("mclr_dwell", {2'b0, v0, b0}, 4'h3);
        cycle();
        chk("mclr_blank", {2'b0, v0, i0}, 4'h0);
        cycle();
        chk("mclr_idle", {1'b0, i0, a0, b0}, 4'h5);

        // Reset in the middle of a blank.
        do_reset();
        en = 1'b1; mask = 4'hF;
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_rst_blank", {3'b0, v0}, 4'h0);
        rst = 1'b1;
        cycle();
        chk("rst_blank", {a0, b0, v0, i0}, 4'h1);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
